// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings and divider-stall FSM states for the
// hazard unit and its sub-modules.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_DIV_DONE = 2'd2
  } div_state_e;

  // ALU operand select: M stage wins over W stage; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wreg_m,
                                         input logic       rw_m,
                                         input logic [4:0] wreg_w,
                                         input logic       rw_w);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != 5'd0 && src == wreg_m && rw_m)      sel = FWD_M;
    else if (src != 5'd0 && src == wreg_w && rw_w) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-control bundle between the datapath/controller (master) and the
// hazard unit (slave), including the divider start/ready handshake.
interface hazard_unit_if #(parameter int unsigned CNT_W = 32);

  logic [4:0]       rsD, rtD, rsE, rtE;
  logic [4:0]       writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE, memtoregM;
  logic             branchD;
  logic             divE;
  logic             div_ready;
  logic             div_start;
  logic             stallF, stallD, stallE;
  logic             flushE, flushM;
  logic             forwardaD, forwardbD;
  logic [1:0]       forwardaE, forwardbE;
  logic             div_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, div_ready,
    input  div_start, stallF, stallD, stallE, flushE, flushM,
           forwardaD, forwardbD, forwardaE, forwardbE, div_err, stall_cnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, div_ready,
    output div_start, stallF, stallD, stallE, flushE, flushM,
           forwardaD, forwardbD, forwardaE, forwardbE, div_err, stall_cnt
  );

endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Multi-cycle divider stall sequencer: start pulse, busy hold, watchdog
// abort, and a single released cycle before returning to idle.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_e,
  input  logic div_ready,
  output logic div_start,
  output logic div_err,
  output logic busy
);

  localparam int unsigned WD_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  div_state_e      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    div_start = 1'b0;
    div_err   = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (div_e) begin
          div_start = 1'b1;
          state_d   = ST_DIV_BUSY;
          wd_d      = '0;
        end
      end
      ST_DIV_BUSY: begin
        busy = 1'b1;
        wd_d = wd_q + WD_W'(1);
        // A result arriving in the timeout cycle still counts as success.
        if (div_ready) begin
          state_d = ST_DIV_DONE;
        end else if (wd_q == WD_LAST) begin
          div_err = 1'b1;
          state_d = ST_DIV_DONE;
        end
      end
      ST_DIV_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch stalls, divider stall sequencing and stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  hazard_unit_if.slave hz
);

  logic             div_busy;
  logic             lwstall, branchstall, hz_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  div_stall_fsm #(.DIV_TIMEOUT(DIV_TIMEOUT)) u_div_fsm (
    .clk       (clk),
    .rst_n     (rst),
    .div_e     (hz.divE),
    .div_ready (hz.div_ready),
    .div_start (hz.div_start),
    .div_err   (hz.div_err),
    .busy      (div_busy)
  );

  always_comb begin
    hz.forwardaE = fwd_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardbE = fwd_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardaD = (hz.rsD != 5'd0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    hz.forwardbD = (hz.rtD != 5'd0) && (hz.rtD == hz.writeregM) && hz.regwriteM;

    lwstall = hz.memtoregE && (hz.rtE != 5'd0) &&
              ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    branchstall = hz.branchD &&
      ((hz.regwriteE && (hz.writeregE != 5'd0) &&
        ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
       (hz.memtoregM && (hz.writeregM != 5'd0) &&
        ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
    hz_stall = lwstall || branchstall;

    // Divider hold freezes F/D/E and bubbles M; load/branch hazards wait.
    if (div_busy) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushE = 1'b0;
      hz.flushM = 1'b1;
    end else begin
      hz.stallF = hz_stall;
      hz.stallD = hz_stall;
      hz.stallE = 1'b0;
      hz.flushE = hz_stall;
      hz.flushM = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (hz.stallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    hz.stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic clk;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hazard_unit_if #(.CNT_W(32)) hz ();

  hazard_unit #(.DIV_TIMEOUT(64), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0;
    hz.branchD = 1'b0; hz.divE = 1'b0; hz.div_ready = 1'b0;
  endtask

  // Advance to 1 ns past the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stalls(input string tag, input logic sf, input logic sd,
                              input logic se, input logic fe, input logic fm);
    check({tag, "_stallF"}, hz.stallF, sf);
    check({tag, "_stallD"}, hz.stallD, sd);
    check({tag, "_stallE"}, hz.stallE, se);
    check({tag, "_flushE"}, hz.flushE, fe);
    check({tag, "_flushM"}, hz.flushM, fm);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #12;
    check_stalls("rst", 0, 0, 0, 0, 0);
    check("rst_div_start", hz.div_start, 0);
    check("rst_div_err", hz.div_err, 0);
    check("rst_fwdaE", hz.forwardaE, 0);
    check("rst_fwdbD", hz.forwardbD, 0);
    check("rst_cnt", hz.stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Forwarding priority
    hz.rsE = 5; hz.writeregM = 5; hz.writeregW = 5; hz.regwriteM = 1; hz.regwriteW = 1;
    #2 check("fwd_m_prio", hz.forwardaE, 2'b10);
    hz.rsD = 5;
    #1 check("fwdaD_m", hz.forwardaD, 1);
    hz.regwriteM = 0;
    #1 check("fwd_w", hz.forwardaE, 2'b01);
    check("fwdaD_off", hz.forwardaD, 0);
    hz.rtE = 5;
    #1 check("fwdbE_w", hz.forwardbE, 2'b01);
    hz.rsE = 0;
    #1 check("fwd_r0", hz.forwardaE, 2'b00);
    hz.writeregM = 0; hz.writeregW = 0; hz.regwriteM = 1; hz.rtE = 0;
    #1 check("fwd_r0_dst", hz.forwardbE, 2'b00);
    check_stalls("fwd_nostall", 0, 0, 0, 0, 0);
    tick();
    check("cnt_0", hz.stall_cnt, 0);

    // Load-use
    clear_inputs();
    hz.memtoregE = 1; hz.rtE = 8; hz.rsD = 8;
    #2 check_stalls("lw", 1, 1, 0, 1, 0);
    tick();
    check("cnt_lw", hz.stall_cnt, 1);
    hz.rtE = 0;
    #2 check_stalls("lw_r0", 0, 0, 0, 0, 0);
    tick();
    check("cnt_lw_r0", hz.stall_cnt, 1);

    // Branch hazards
    clear_inputs();
    hz.branchD = 1; hz.regwriteE = 1; hz.writeregE = 9; hz.rtD = 9;
    #2 check_stalls("br_e", 1, 1, 0, 1, 0);
    tick();
    hz.regwriteE = 0; hz.writeregE = 0; hz.memtoregM = 1; hz.writeregM = 9;
    #2 check_stalls("br_m_load", 1, 1, 0, 1, 0);
    tick();
    hz.memtoregM = 0; hz.regwriteM = 1;
    #2 check_stalls("br_m_alu", 0, 0, 0, 0, 0);
    check("br_fwdbD", hz.forwardbD, 1);
    hz.regwriteM = 0; hz.regwriteE = 1; hz.writeregE = 0; hz.rtD = 0; hz.rsD = 0;
    #1 check("br_r0", hz.stallD, 0);
    tick();
    check("cnt_br", hz.stall_cnt, 3);

    // Divide with ready after 10 busy cycles; load hazard held throughout
    clear_inputs();
    hz.divE = 1;
    #2 check("div_start", hz.div_start, 1);
    check("div_idle_stallE", hz.stallE, 0);
    tick();
    hz.memtoregE = 1; hz.rtE = 8; hz.rsD = 8;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) hz.div_ready = 1;
      #2 check_stalls("div_busy", 1, 1, 1, 0, 1);
      check("div_busy_start", hz.div_start, 0);
      check("div_busy_err", hz.div_err, 0);
      tick();
    end
    hz.div_ready = 0; hz.memtoregE = 0;
    #2 check_stalls("div_done", 0, 0, 0, 0, 0);
    check("div_done_nostart", hz.div_start, 0);
    hz.divE = 0;
    tick();
    check("div_idle_nostart", hz.div_start, 0);
    check("cnt_div", hz.stall_cnt, 13);

    // Watchdog timeout
    hz.divE = 1;
    tick();
    for (int i = 1; i <= 64; i++) begin
      #2 check("to_err", hz.div_err, (i == 64) ? 1 : 0);
      check("to_stallE", hz.stallE, 1);
      tick();
    end
    #2 check_stalls("to_done", 0, 0, 0, 0, 0);
    check("to_done_err", hz.div_err, 0);
    check("to_done_nostart", hz.div_start, 0);
    hz.divE = 0;
    tick();
    check("to_idle_stallE", hz.stallE, 0);
    check("cnt_to", hz.stall_cnt, 77);

    // Ready in the timeout cycle beats the watchdog
    hz.divE = 1;
    tick();
    hz.divE = 0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) hz.div_ready = 1;
      #2 check("race_err", hz.div_err, 0);
      tick();
    end
    hz.div_ready = 0;
    #2 check("race_done_stallE", hz.stallE, 0);
    tick();
    check("cnt_race", hz.stall_cnt, 141);

    // Async reset in the middle of a divide
    hz.divE = 1;
    tick();
    hz.divE = 0;
    tick();
    tick();
    #3 check("mid_busy", hz.stallE, 1);
    rst = 1'b0;
    #1 check_stalls("arst", 0, 0, 0, 0, 0);
    check("arst_err", hz.div_err, 0);
    check("arst_start", hz.div_start, 0);
    check("arst_cnt", hz.stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_stallE", hz.stallE, 0);
    check("post_rst_start", hz.div_start, 0);
    check("post_rst_cnt", hz.stall_cnt, 0);
    hz.divE = 1;
    #2 check("fresh_start", hz.div_start, 1);
    tick();
    hz.divE = 0;
    #2 check("fresh_busy", hz.stallE, 1);
    hz.div_ready = 1;
    tick();
    hz.div_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
